pwm_duty_sequencer: RTL and testbench
=====================================

Name: pwm_duty_sequencer

Overview:
Generates the 4-bit duty word that drives the downstream PWM stage. It produces a "breathing" profile: ramp up, hold at peak, ramp down, hold at trough, repeat. Step rate is set by a prescaler scaled by a run-time speed select. Enable, freeze and a completed-cycle counter are provided for LED demo boards.

Parameters:
- STEP_DIV, 50000, clocks per duty step at speed=0; must be at least 1.
- HOLD_STEPS, 8, steps spent in each hold state; 0 skips the holds.
- DUTY_MIN, 0, trough duty value; 4-bit.
- DUTY_MAX, 15, peak duty value; 4-bit; DUTY_MIN < DUTY_MAX is required.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  run enable; low forces IDLE.
- freeze  in  1  pauses the prescaler and all stepping; state is held.
- speed  in  2  step interval = STEP_DIV << speed clocks.
- duty  out  4  registered duty word to the PWM stage.
- phase  out  3  current state: IDLE=0, RAMP_UP=1, HOLD_HIGH=2, RAMP_DOWN=3, HOLD_LOW=4.
- cycle_done  out  1  one-clock pulse when HOLD_LOW exits to RAMP_UP.
- cycle_cnt  out  8  count of completed breathe cycles; wraps 255 to 0.

Behaviour:
- Reset (reset=0, asynchronous): duty=DUTY_MIN, phase=IDLE, cycle_done=0, cycle_cnt=0, prescaler=0, hold counter=0. Asserting reset mid-ramp aborts the ramp immediately.
- Prescaler:
  - 24-bit counter; STEP_DIV<<3 must fit in 24 bits.
  - Terminal value term = (STEP_DIV<<speed)-1.
  - A tick occurs in any cycle where count >= term (not frozen, phase != IDLE); the counter then returns to 0. Otherwise it increments.
  - Because the compare is >=, reducing speed mid-interval yields an immediate tick with no long wait.
- Stepping latency: a tick in cycle N updates duty/phase at the end of cycle N, visible in cycle N+1.
- freeze=1: prescaler holds its value, no ticks, and duty/phase/hold counter hold. Releasing freeze resumes from the held count.
- en=0 (any state): next edge sets phase=IDLE, duty=DUTY_MIN, prescaler=0, hold counter=0. cycle_cnt is retained. en has priority over freeze.
- State machine:
  - IDLE: when en=1, go to RAMP_UP next edge with prescaler=0. There is no tick in IDLE.
  - RAMP_UP: on tick, duty+1. If the new duty equals DUTY_MAX, go to HOLD_HIGH (or straight to RAMP_DOWN if HOLD_STEPS=0).
  - HOLD_HIGH: on tick, hold+1. When hold reaches HOLD_STEPS-1 on a tick, go to RAMP_DOWN and clear hold. Duty stays at DUTY_MAX.
  - RAMP_DOWN: on tick, duty-1. If the new duty equals DUTY_MIN, go to HOLD_LOW (or straight to RAMP_UP if HOLD_STEPS=0).
  - HOLD_LOW: same hold rule as HOLD_HIGH. Exit to RAMP_UP and pulse cycle_done for exactly one clock.
  - cycle_cnt increments on the same edge as cycle_done. With HOLD_STEPS=0, cycle_done pulses on the RAMP_DOWN-to-RAMP_UP transition.
- Duty arithmetic:
  - Duty never leaves [DUTY_MIN, DUTY_MAX].
  - No wrap: 15+1 or 0-1 can never occur, because the state changes on reaching the bound.
  - Duty changes by at most 1 per tick.
- Illegal phase encodings (5-7) return to IDLE on the next edge with duty=DUTY_MIN.
- Simultaneous events:
  - en falling on a tick cycle: en wins; there is no duty step or cycle_done.
  - speed change on a tick cycle: the current tick is honoured, and the new term applies from the next cycle.

Test Plan:
Common settings for all scenarios: STEP_DIV=4, HOLD_STEPS=2, DUTY 0..15, speed=0.
1. Reset then en=1 -> phase=1 one cycle after en rises. Duty goes 0,1,...,15, incrementing every 4 clocks, and reaches 15 exactly 60 clocks after entering RAMP_UP. phase=2 then.
2. Free run of one full period -> 34 ticks = 136 clocks from RAMP_UP entry to the next RAMP_UP entry. cycle_done is high for exactly 1 clock, cycle_cnt goes 0 to 1, and after 256 periods it wraps to 0.
3. speed=2 during RAMP_UP, then switch to speed=0 when the prescaler is at 10 -> step spacing is 16 clocks, and a tick occurs on the very next cycle after the switch (10 >= 3).
4. freeze=1 for 20 clocks mid RAMP_DOWN at duty=7 -> duty, phase and prescaler are unchanged for those 20 clocks. The next step occurs after the remaining prescaler count on release.
5. en=0 at duty=9 in RAMP_UP, coinciding with a tick -> next edge duty=0, phase=0, no step to 10, cycle_cnt unchanged. Re-enable restarts from 0.
6. Async reset=0 mid HOLD_HIGH between clock edges -> outputs go to reset values immediately, without waiting for clk. Also: HOLD_STEPS=0 build goes directly 15 to 14 on consecutive ticks, with no HOLD phases observed.

Source files
------------

// File: rtl/pwm_duty_sequencer.sv
// Breathing duty-word generator: ramp up, hold high, ramp down, hold low, repeat.
// One duty step per prescaler tick; the tick interval is STEP_DIV << speed clocks.
module pwm_duty_sequencer #(
    parameter int unsigned STEP_DIV   = 50000,
    parameter int unsigned HOLD_STEPS = 8,
    parameter logic [3:0]  DUTY_MIN   = 4'd0,
    parameter logic [3:0]  DUTY_MAX   = 4'd15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       freeze,
    input  logic [1:0] speed,
    output logic [3:0] duty,
    output logic [2:0] phase,
    output logic       cycle_done,
    output logic [7:0] cycle_cnt
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RAMP_UP   = 3'd1,
        HOLD_HIGH = 3'd2,
        RAMP_DOWN = 3'd3,
        HOLD_LOW  = 3'd4
    } phase_t;

    localparam logic [15:0] HOLD_LAST = 16'(HOLD_STEPS - 1);

    if (STEP_DIV == 0 || STEP_DIV > 32'h001F_FFFF) begin : g_bad_div
        $error("pwm_duty_sequencer: STEP_DIV must be >= 1 and STEP_DIV<<3 must fit in 24 bits");
    end
    if (DUTY_MIN >= DUTY_MAX) begin : g_bad_duty
        $error("pwm_duty_sequencer: DUTY_MIN must be below DUTY_MAX");
    end

    phase_t      state, state_nx;
    logic [23:0] pre, pre_nx;
    logic [15:0] hold, hold_nx;
    logic [3:0]  duty_nx;
    logic        done_nx;
    logic [7:0]  cnt_nx;
    logic [23:0] term;
    logic        active;
    logic        legal;
    logic        tick;

    // >= rather than == so that lowering speed mid-interval ticks at once.
    assign term   = (24'(STEP_DIV) << speed) - 24'd1;
    assign active = (state == RAMP_UP) || (state == HOLD_HIGH) ||
                    (state == RAMP_DOWN) || (state == HOLD_LOW);
    assign legal  = active || (state == IDLE);
    assign tick   = en && !freeze && active && (pre >= term);
    assign phase  = state;

    always_comb begin
        state_nx = state;
        duty_nx  = duty;
        pre_nx   = pre;
        hold_nx  = hold;
        done_nx  = 1'b0;
        cnt_nx   = cycle_cnt;

        if (!en || !legal) begin
            state_nx = IDLE;
            duty_nx  = DUTY_MIN;
            pre_nx   = '0;
            hold_nx  = '0;
        end else if (freeze) begin
            state_nx = state;
        end else if (state == IDLE) begin
            state_nx = RAMP_UP;
            pre_nx   = '0;
        end else if (!tick) begin
            pre_nx = pre + 24'd1;
        end else begin
            pre_nx = '0;
            case (state)
                RAMP_UP: begin
                    duty_nx = duty + 4'd1;
                    if (duty_nx == DUTY_MAX)
                        state_nx = (HOLD_STEPS == 0) ? RAMP_DOWN : HOLD_HIGH;
                end
                HOLD_HIGH: begin
                    if (hold == HOLD_LAST) begin
                        hold_nx  = '0;
                        state_nx = RAMP_DOWN;
                    end else begin
                        hold_nx = hold + 16'd1;
                    end
                end
                RAMP_DOWN: begin
                    duty_nx = duty - 4'd1;
                    if (duty_nx == DUTY_MIN) begin
                        if (HOLD_STEPS == 0) begin
                            state_nx = RAMP_UP;
                            done_nx  = 1'b1;
                            cnt_nx   = cycle_cnt + 8'd1;
                        end else begin
                            state_nx = HOLD_LOW;
                        end
                    end
                end
                HOLD_LOW: begin
                    if (hold == HOLD_LAST) begin
                        hold_nx  = '0;
                        state_nx = RAMP_UP;
                        done_nx  = 1'b1;
                        cnt_nx   = cycle_cnt + 8'd1;
                    end else begin
                        hold_nx = hold + 16'd1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            duty       <= DUTY_MIN;
            pre        <= '0;
            hold       <= '0;
            cycle_done <= 1'b0;
            cycle_cnt  <= '0;
        end else begin
            state      <= state_nx;
            duty       <= duty_nx;
            pre        <= pre_nx;
            hold       <= hold_nx;
            cycle_done <= done_nx;
            cycle_cnt  <= cnt_nx;
        end
    end

    // A completed cycle always lands the sequencer back at the start of the ramp.
    a_done_restart: assert property (@(posedge clk) disable iff (!reset)
        cycle_done |-> state == RAMP_UP);

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Bench for pwm_duty_sequencer: two builds (HOLD_STEPS=2 and 0) driven together and
// compared every cycle against a position-in-profile reference model.
module tb_pwm_duty_sequencer;

    localparam int SD = 4;
    localparam int R  = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       freeze = 1'b0;
    logic [1:0] speed = 2'd0;

    logic [3:0] duty_a, duty_b;
    logic [2:0] phase_a, phase_b;
    logic       done_a, done_b;
    logic [7:0] cnt_a, cnt_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pwm_duty_sequencer #(.STEP_DIV(SD), .HOLD_STEPS(2), .DUTY_MIN(4'd0), .DUTY_MAX(4'd15)) dut_a (
        .clk(clk), .reset(reset), .en(en), .freeze(freeze), .speed(speed),
        .duty(duty_a), .phase(phase_a), .cycle_done(done_a), .cycle_cnt(cnt_a));

    pwm_duty_sequencer #(.STEP_DIV(SD), .HOLD_STEPS(0), .DUTY_MIN(4'd0), .DUTY_MAX(4'd15)) dut_b (
        .clk(clk), .reset(reset), .en(en), .freeze(freeze), .speed(speed),
        .duty(duty_b), .phase(phase_b), .cycle_done(done_b), .cycle_cnt(cnt_b));

    // Model: the profile is a ring of 2R+2H positions; a tick advances one position.
    int hs[2] = '{2, 0};
    int m_cnt[2];
    int m_pos[2];
    int m_cc[2];
    bit m_idle[2];
    bit m_done[2];

    task automatic m_reset(input int i);
        m_cnt[i] = 0; m_pos[i] = 0; m_cc[i] = 0; m_idle[i] = 1'b1; m_done[i] = 1'b0;
    endtask

    task automatic m_step(input int i);
        m_done[i] = 1'b0;
        if (!en) begin
            m_idle[i] = 1'b1; m_cnt[i] = 0; m_pos[i] = 0;
        end else if (freeze) begin
            m_done[i] = 1'b0;
        end else if (m_idle[i]) begin
            m_idle[i] = 1'b0; m_cnt[i] = 0; m_pos[i] = 0;
        end else if (m_cnt[i] >= (SD << speed) - 1) begin
            m_cnt[i] = 0;
            m_pos[i] = (m_pos[i] + 1) % (2 * R + 2 * hs[i]);
            if (m_pos[i] == 0) begin
                m_done[i] = 1'b1;
                m_cc[i]   = (m_cc[i] + 1) % 256;
            end
        end else begin
            m_cnt[i] = m_cnt[i] + 1;
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_reset(0); m_reset(1);
        end else begin
            m_step(0); m_step(1);
        end
    end

    task automatic exp_out(input int i, output int d, output int ph);
        int p, h;
        p = m_pos[i];
        h = hs[i];
        if (m_idle[i])              begin d = 0;               ph = 0; end
        else if (p < R)             begin d = p;               ph = 1; end
        else if (p < R + h)         begin d = 15;              ph = 2; end
        else if (p < 2 * R + h)     begin d = 15 - (p - R - h); ph = 3; end
        else                        begin d = 0;               ph = 4; end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d, want %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic check_all();
        int d, ph;
        exp_out(0, d, ph);
        chk("a.duty", int'(duty_a), d);
        chk("a.phase", int'(phase_a), ph);
        chk("a.cycle_done", int'(done_a), int'(m_done[0]));
        chk("a.cycle_cnt", int'(cnt_a), m_cc[0]);
        exp_out(1, d, ph);
        chk("b.duty", int'(duty_b), d);
        chk("b.phase", int'(phase_b), ph);
        chk("b.cycle_done", int'(done_b), int'(m_done[1]));
        chk("b.cycle_cnt", int'(cnt_b), m_cc[1]);
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check_all();
        end
    endtask

    // Advance until the HOLD_STEPS=2 model sits at position p with prescaler c.
    task automatic run_to(input int p, input int c, input string tag);
        int w;
        w = 0;
        while (!(m_pos[0] == p && m_cnt[0] == c && !m_idle[0]) && w < 3000) begin
            cycles(1);
            w++;
        end
        chk(tag, int'(w < 3000), 1);
    endtask

    initial begin
        m_reset(0); m_reset(1);
        cycles(3);
        reset = 1'b1;
        cycles(2);

        // Ramp from enable, then one full period and a bit.
        en = 1'b1;
        cycles(70);
        cycles(140);

        // Slow ramp, then drop to speed 0 with the prescaler at 10.
        en = 1'b0; cycles(1);
        en = 1'b1; speed = 2'd2;
        run_to(2, 10, "wait_pre10");
        speed = 2'd0;
        cycles(40);

        // Freeze mid ramp-down at duty 7.
        run_to(R + 2 + 8, 1, "wait_duty7");
        freeze = 1'b1; cycles(20);
        freeze = 1'b0; cycles(20);

        // Drop en on a tick cycle at duty 9.
        en = 1'b0; cycles(1);
        en = 1'b1;
        run_to(9, 3, "wait_duty9_tick");
        en = 1'b0; cycles(2);
        en = 1'b1; cycles(20);

        // Asynchronous reset between edges during HOLD_HIGH.
        run_to(R, 1, "wait_hold_high");
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check_all();
        @(negedge clk); check_all();
        reset = 1'b1;
        cycles(5);

        // Random en/freeze/speed activity.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(63) == 0) en = ~en;
            if ($urandom_range(15) == 0) freeze = ~freeze;
            if ($urandom_range(31) == 0) speed = 2'($urandom_range(3));
            if (!en && $urandom_range(3) == 0) en = 1'b1;
            cycles(1);
        end

        // Long free run: cycle_cnt wraps past 255.
        en = 1'b1; freeze = 1'b0; speed = 2'd0;
        cycles(256 * 136 + 60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
